// File: rtl/alu_pkg.sv
// alu_pkg: constants and the issue bundle shared by the
// decode/issue stage, its register file and the ALU.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_EQ  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
        logic [4:0]        dest;
        logic              wr;
        logic              branch;
        logic              illegal;
    } issue_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 32x32 register file, r0 hardwired to zero.
// Ports: clk, rst_n (async clear); ra1/ra2 -> rd1/rd2 async
// reads with write-through bypass; we/wa/wd write port.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != 5'd0) begin
            mem[wa] <= wd;
        end
    end

    // A same-cycle writeback is visible to the reader.
    always_comb begin
        if (ra1 == 5'd0) begin
            rd1 = '0;
        end else if (we && wa == ra1) begin
            rd1 = wd;
        end else begin
            rd1 = mem[ra1];
        end
    end

    always_comb begin
        if (ra2 == 5'd0) begin
            rd2 = '0;
        end else if (we && wa == ra2) begin
            rd2 = wd;
        end else begin
            rd2 = mem[ra2];
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage feeding the 32-bit ALU.
// Ports: in_* instruction handshake; wb_* writeback from
// downstream; out_* registered {a,b,op,...} bundle handshake.
module alu_issue
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_op,
    output logic [4:0]        out_dest,
    output logic              out_wr,
    output logic              out_branch,
    output logic              out_illegal
);

    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        unused_shamt;

    assign opc = in_instr[31:26];
    assign rs  = in_instr[25:21];
    assign rt  = in_instr[20:16];
    assign rd  = in_instr[15:11];
    assign fn  = in_instr[5:0];
    assign imm = in_instr[15:0];
    assign unused_shamt = ^in_instr[10:6];

    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;

    assign sext = {{(DATA_W-16){imm[15]}}, imm};
    assign zext = {{(DATA_W-16){1'b0}}, imm};

    alu_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (ra),
        .rd2   (rb),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    logic       r_ok;
    logic [2:0] r_op;

    always_comb begin
        r_ok = 1'b1;
        r_op = ALU_ADD;
        unique case (fn)
            FN_ADD:  r_op = ALU_ADD;
            FN_SUB:  r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_SLT:  r_op = ALU_SLT;
            default: r_ok = 1'b0;
        endcase
    end

    issue_t dec;

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (opc == OP_RTYPE) && r_ok: begin
                dec.a    = ra;
                dec.b    = rb;
                dec.op   = r_op;
                dec.dest = rd;
                dec.wr   = 1'b1;
            end
            opc == OP_ADDI: begin
                dec.a    = ra;
                dec.b    = sext;
                dec.op   = ALU_ADD;
                dec.dest = rt;
                dec.wr   = 1'b1;
            end
            opc == OP_SLTI: begin
                dec.a    = ra;
                dec.b    = sext;
                dec.op   = ALU_SLT;
                dec.dest = rt;
                dec.wr   = 1'b1;
            end
            opc == OP_ANDI: begin
                dec.a    = ra;
                dec.b    = zext;
                dec.op   = ALU_AND;
                dec.dest = rt;
                dec.wr   = 1'b1;
            end
            opc == OP_ORI: begin
                dec.a    = ra;
                dec.b    = zext;
                dec.op   = ALU_OR;
                dec.dest = rt;
                dec.wr   = 1'b1;
            end
            opc == OP_BEQ: begin
                dec.a      = ra;
                dec.b      = rb;
                dec.op     = ALU_EQ;
                dec.branch = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    logic [NREG-1:0] busy;
    logic            use_rt;
    logic            haz_rs;
    logic            haz_rt;
    logic            accept;

    assign use_rt = (opc == OP_RTYPE) || (opc == OP_BEQ);

    // A writeback landing this cycle resolves the hazard,
    // since the bypass delivers its value to the read.
    assign haz_rs = busy[rs] && (rs != 5'd0)
                  && !(wb_en && wb_addr == rs);
    assign haz_rt = busy[rt] && (rt != 5'd0)
                  && !(wb_en && wb_addr == rt);

    assign in_ready = (!out_valid || out_ready)
                    && !haz_rs && !(use_rt && haz_rt);
    assign accept   = in_valid && in_ready;

    // Later assignment wins: a new producer's set beats a
    // same-cycle writeback clear of the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wb_en) begin
                busy[wb_addr] <= 1'b0;
            end
            if (accept && dec.wr && dec.dest != 5'd0) begin
                busy[dec.dest] <= 1'b1;
            end
        end
    end

    issue_t q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_a       = q.a;
    assign out_b       = q.b;
    assign out_op      = q.op;
    assign out_dest    = q.dest;
    assign out_wr      = q.wr;
    assign out_branch  = q.branch;
    assign out_illegal = q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven and scoreboard bench for the
// alu_issue decode/issue stage.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic [4:0]  out_dest;
    logic        out_wr;
    logic        out_branch;
    logic        out_illegal;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_op      (out_op),
        .out_dest    (out_dest),
        .out_wr      (out_wr),
        .out_branch  (out_branch),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic        wr;
        logic        br;
        logic        ill;
    } vec_t;

    vec_t sb[$];
    vec_t tab[14];
    vec_t e;
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(
        input logic [31:0] instr, input logic [31:0] a,
        input logic [31:0] b, input logic [2:0] op,
        input logic [4:0] dest, input logic wr,
        input logic br, input logic ill);
        vec_t v;
        v.instr = instr;
        v.a     = a;
        v.b     = b;
        v.op    = op;
        v.dest  = dest;
        v.wr    = wr;
        v.br    = br;
        v.ill   = ill;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = v.instr;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL stall timeout: instr %h got in_ready=0 want 1",
                     v.instr);
        end else begin
            sb.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    logic [74:0] cur;
    logic [74:0] held;
    logic        hold_prev = 1'b0;
    logic        ok;

    always @(negedge clk) begin
        cur = {out_a, out_b, out_op, out_dest,
               out_wr, out_branch, out_illegal};
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                total++;
                if (!out_valid || cur !== held) begin
                    bad++;
                    $display("FAIL hold: got v=%b %h want v=1 %h",
                             out_valid, cur, held);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected issue: got a=%h b=%h want none",
                             out_a, out_b);
                end else begin
                    e = sb.pop_front();
                    ok = out_a === e.a && out_b === e.b
                      && out_op === e.op && out_wr === e.wr
                      && out_branch === e.br
                      && out_illegal === e.ill
                      && (!e.wr || out_dest === e.dest);
                    if (!ok) begin
                        bad++;
                        $display("FAIL bundle %h: got a=%h b=%h op=%0d d=%0d w=%b br=%b il=%b want a=%h b=%h op=%0d d=%0d w=%b br=%b il=%b",
                                 e.instr, out_a, out_b, out_op, out_dest,
                                 out_wr, out_branch, out_illegal,
                                 e.a, e.b, e.op, e.dest, e.wr, e.br, e.ill);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            held = cur;
        end
    end

    initial begin
        tab[0]  = mk(32'h00225020, 32'd23, 32'h100, 3'd0, 5'd10, 1, 0, 0);
        tab[1]  = mk(32'h00C75822, 32'hF0F01234, 32'hFFFFFFFB, 3'd1, 5'd11, 1, 0, 0);
        tab[2]  = mk(32'h00C26024, 32'hF0F01234, 32'h100, 3'd2, 5'd12, 1, 0, 0);
        tab[3]  = mk(32'h00276825, 32'd23, 32'hFFFFFFFB, 3'd3, 5'd13, 1, 0, 0);
        tab[4]  = mk(32'h00E1702A, 32'hFFFFFFFB, 32'd23, 3'd5, 5'd14, 1, 0, 0);
        tab[5]  = mk(32'h282FFFFF, 32'd23, 32'hFFFFFFFF, 3'd5, 5'd15, 1, 0, 0);
        tab[6]  = mk(32'h3430FFFF, 32'd23, 32'h0000FFFF, 3'd3, 5'd16, 1, 0, 0);
        tab[7]  = mk(32'h30D18001, 32'hF0F01234, 32'h00008001, 3'd2, 5'd17, 1, 0, 0);
        tab[8]  = mk(32'h20528000, 32'h100, 32'hFFFF8000, 3'd0, 5'd18, 1, 0, 0);
        tab[9]  = mk(32'h10220003, 32'd23, 32'h100, 3'd4, 5'd0, 0, 1, 0);
        tab[10] = mk(32'hFC225020, 32'd0, 32'd0, 3'd0, 5'd0, 0, 0, 1);
        tab[11] = mk(32'h00225021, 32'd0, 32'd0, 3'd0, 5'd0, 0, 0, 1);
        tab[12] = mk(32'h20000005, 32'd0, 32'd5, 3'd0, 5'd0, 1, 0, 0);
        tab[13] = mk(32'h00019820, 32'd0, 32'd23, 3'd0, 5'd19, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_a", out_a, 0);
        chk("rst out_b", out_b, 0);
        chk("rst fields", {out_op, out_dest, out_wr,
                           out_branch, out_illegal}, 0);
        rst_n = 1'b1;
        #1;
        chk("idle in_ready", in_ready, 1);

        // addi r1,r0,23 then dependent sub r3,r1,r2
        send(mk(32'h20010017, 32'd0, 32'd23, 3'd0, 5'd1, 1, 0, 0));
        in_valid = 1'b1;
        in_instr = 32'h00221822;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("raw stall in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        wb_en   = 1'b1;
        wb_addr = 5'd1;
        wb_data = 32'd23;
        #1;
        chk("raw release in_ready", in_ready, 1);
        sb.push_back(mk(32'h00221822, 32'd23, 32'd0, 3'd1, 5'd3, 1, 0, 0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;

        // drain, then hold the or r4,r1,r2 bundle
        @(posedge clk);
        #1;
        chk("drain out_valid", out_valid, 0);
        out_ready = 1'b0;
        send(mk(32'h00222025, 32'd23, 32'd0, 3'd3, 5'd4, 1, 0, 0));
        in_valid = 1'b1;
        in_instr = 32'h2825FFFF;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold in_ready", in_ready, 0);
            chk("hold out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("hold release in_ready", in_ready, 1);
        sb.push_back(mk(32'h2825FFFF, 32'd23, 32'hFFFFFFFF, 3'd5, 5'd5, 1, 0, 0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(mk(32'h3425FFFF, 32'd23, 32'h0000FFFF, 3'd3, 5'd5, 1, 0, 0));

        wb(5'd2, 32'h100);
        wb(5'd6, 32'hF0F01234);
        wb(5'd7, 32'hFFFFFFFB);
        for (int i = 0; i < 14; i++) begin
            send(tab[i]);
        end
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        chk("drain queue empty", sb.size(), 0);

        // reset while addi r1,r1,1 is held at the output
        out_ready = 1'b0;
        send(mk(32'h20210001, 32'd23, 32'd1, 3'd0, 5'd1, 1, 0, 0));
        chk("pre-reset out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset out_a", out_a, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        send(mk(32'h0022A820, 32'd0, 32'd0, 3'd0, 5'd21, 1, 0, 0));
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        chk("final queue empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage directly upstream of the 32-bit ALU.
- Accepts MIPS-style instructions over a valid/ready handshake and reads operands from an internal 32x32 register file.
- Decodes the 3-bit ALU op and presents a registered {a, b, op} bundle to the ALU through an output valid/ready register.
- A per-register busy scoreboard stalls read-after-write hazards until the downstream writeback port returns the result.

Parameters:
- DATA_W, 32, operand/result width; fixed to match the ALU.
- NREG, 32, register count; register 0 reads as zero.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  instruction present
- in_instr  in  32  instruction word
- in_ready  out  1  instruction accepted when in_valid && in_ready
- wb_en  in  1  writeback strobe from downstream
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback value
- out_valid  out  1  issue bundle valid
- out_ready  in  1  ALU side consumes when out_valid && out_ready
- out_a  out  32  ALU operand a
- out_b  out  32  ALU operand b
- out_op  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 eq, 101 slt
- out_dest  out  5  destination register
- out_wr  out  1  instruction writes out_dest
- out_branch  out  1  instruction is beq; the consumer tests the ALU result
- out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0; out_a, out_b, out_op, out_dest, out_wr, out_branch, out_illegal all 0; all registers 0; all busy bits 0. Asserting reset mid-operation discards any in-flight bundle.
- Fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
- R-type decode (opcode 000000), a=R[rs], b=R[rt], dest=rd, wr=1:
  - funct 100000 -> 000 (add)
  - funct 100010 -> 001 (sub)
  - funct 100100 -> 010 (and)
  - funct 100101 -> 011 (or)
  - funct 101010 -> 101 (slt)
- I-type decode, a=R[rs], dest=rt, wr=1:
  - addi 001000 -> 000, b=sign-extended imm
  - slti 001010 -> 101, b=sign-extended imm
  - andi 001100 -> 010, b=zero-extended imm
  - ori 001101 -> 011, b=zero-extended imm
- beq (000100): op=100, a=R[rs], b=R[rt], wr=0, branch=1.
- Any other opcode/funct: illegal=1, op=000, a=b=0, wr=0. The instruction is still consumed and issued so downstream can trap.
- Register read: r0 always reads 0. If wb_en && wb_addr==src && src!=0 in the same cycle, the read returns wb_data (write-through bypass).
- Writeback: on wb_en, R[wb_addr] <= wb_data, except writes to r0, which are ignored. Writeback also clears busy[wb_addr].
- Hazard condition, evaluated for rs always and for rt only for R-type and beq:
  - busy[src] && !(wb_en && wb_addr==src) && src!=0
- in_ready = (!out_valid || out_ready) && !hazard. in_ready is combinational; it may depend on in_instr.
- On accept:
  - output register loads the decoded bundle; out_valid=1 the next cycle (1-cycle latency)
  - if wr && dest!=0, busy[dest] <= 1
- Simultaneous accept setting busy[x] and wb_en clearing busy[x]: set wins.
- Output hold: while out_valid && !out_ready, all out_* fields stay stable.
- Drain: if out_ready with no accept, out_valid falls to 0 next cycle.
- Back-to-back: full throughput of one instruction per cycle when there is no hazard and out_ready=1.
- A stalled instruction produces no side effects. The upstream source must hold in_instr stable while in_valid && !in_ready.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op localparams (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_EQ=3'b100, ALU_SLT=3'b101), shared with the ALU
  - opcode/funct constants
  - DATA_W
- One sub-module, alu_regfile: 32x32 storage, two async read ports with write-through bypass, one write port, r0 hardwired zero, async active-low clear.
- Decode, scoreboard and output register stay in alu_issue.

Test Plan:
- Reset then `addi r1,r0,23` (0x20010017) -> next cycle out_valid=1, a=0, b=23, op=000, dest=1, wr=1; busy[1]=1.
- Next cycle with busy[1] set, `sub r3,r1,r2` -> in_ready=0 until wb_en (wb_addr=1, wb_data=23). In that wb cycle it is accepted: a=23, op=001, dest=3.
- Hold out_ready=0 for 3 cycles after issuing `or r4,r1,r2` -> out_valid stays 1, bundle unchanged, in_ready=0. out_ready=1 -> consumed, and the next instruction is accepted the same cycle.
- `slti r5,r1,0xFFFF` -> b=0xFFFFFFFF, op=101. `ori r5,r1,0xFFFF` -> b=0x0000FFFF, op=011.
- `beq r1,r2,x` -> op=100, wr=0, branch=1, no busy set. Opcode 0x3F -> illegal=1, wr=0. `addi r0,r0,5` -> r0 never busy and still reads 0 afterward.
- Assert rst_n low while out_valid=1 -> out_valid drops to 0 immediately without a clock; busy bits and registers clear.
